serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial N-bit subtractor built around the full-subtractor cell (diff/borrow) plus a registered borrow, computing A − B − bin one bit per clock, LSB first. It consumes the half/full subtractor logic of the combinational library and feeds a sequenced datapath that needs a low-area subtract with a start/done handshake.

## Interface
- WIDTH, 8, operand width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on rising clk edge in IDLE or DONE
- in1  input  WIDTH  minuend A, captured when start is accepted
- in2  input  WIDTH  subtrahend B, captured when start is accepted
- bin  input  1  borrow-in, captured when start is accepted
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result valid
- diff  output  WIDTH  A − B − bin mod 2^WIDTH, held until next result
- bow  output  1  final borrow-out (1 = A < B + bin unsigned), held
- bit_valid  output  1  high in each cycle a serial bit is produced
- bit_diff  output  1  current serial difference bit
- bit_bow  output  1  current serial borrow out of that bit

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: start=1 → capture in1, in2 into shift registers, bin into borrow reg, bit counter=0, → RUN. start=0 → stay.
- RUN: each cycle, bit i = counter: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br). d shifted into result register MSB end (LSB-first fill); br ← br_next; operands shift right; counter++.
- After bit WIDTH−1: diff ← completed result, bow ← br_next, → DONE.
- DONE: done=1 for exactly one cycle. start=1 here is accepted (same capture as IDLE, → RUN); else → IDLE.
- start during RUN ignored; in1/in2/bin changes during RUN have no effect.
- bit_valid = busy; bit_diff/bit_bow are the combinational d/br_next of the current bit (valid only when bit_valid=1).
- diff/bow update only on RUN→DONE transition; hold otherwise.
- Counter width $clog2(WIDTH); no wrap occurs since RUN exits at WIDTH−1.

## Timing
- Reset values (async, immediate): state=IDLE, busy=0, done=0, diff=0, bow=0, bit_valid=0, internal borrow/counter/shift regs=0.
- start accepted at edge E0 → busy=1 from E0 to edge E0+WIDTH; bit i presented during cycle between E0+i and E0+i+1.
- diff/bow valid and done=1 from edge E0+WIDTH for one cycle. Latency start→done = WIDTH cycles.
- Back-to-back: start held high in DONE → next RUN begins at E0+WIDTH+1; throughput one result per WIDTH+1 cycles.
- rst asserted mid-RUN: immediately abort to IDLE, all outputs to reset values; no done for the aborted operation. After rst deasserts, first start accepted on the next edge.
- done and busy never high in the same cycle.

## Test plan
- WIDTH=8, in1=5, in2=3, bin=0, start 1 cycle → after 8 cycles done=1, diff=0x02, bow=0; bit_diff sequence LSB-first 0,1,0,0,0,0,0,0.
- in1=3, in2=5, bin=0 → diff=0xFE, bow=1; in1=0, in2=0, bin=1 → diff=0xFF, bow=1.
- Start pulsed again and in1/in2 changed at RUN cycle 3 → result equals first operands, done only once after 8 cycles.
- start held high continuously with in1=0xA0, in2=0x0F → done pulses every 9 cycles, diff=0x91, bow=0 each time; busy/done never overlap.
- rst asserted at RUN cycle 4 → busy, done, diff, bow, bit_valid all 0 immediately; no done follows; new start afterwards completes correctly.
- WIDTH=4 exhaustive: all 16×16×2 in1/in2/bin combos → diff=(in1−in2−bin) mod 16, bow=(in1 < in2+bin).

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The requester drives start and the operands; the subtractor returns the result, its status and the serial bit tap.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bow;
  logic             bit_valid;
  logic             bit_diff;
  logic             bit_bow;

  modport master (
    output start, in1, in2, bin,
    input  busy, done, diff, bow, bit_valid, bit_diff, bit_bow
  );

  modport slave (
    input  start, in1, in2, bin,
    output busy, done, diff, bow, bit_valid, bit_diff, bit_bow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - bin subtractor, LSB first, one bit per clock.
// A start/done handshake sequences each operation through the states IDLE, RUN and DONE.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bow_q, bow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             d_c, br_next_c;

  // Full-subtractor cell on the current LSB of each operand
  assign d_c       = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next_c = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bow_d   = bow_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          a_d     = bus.in1;
          b_d     = bus.in2;
          br_d    = bus.bin;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = {d_c, res_q[WIDTH-1:1]};
        br_d  = br_next_c;
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d  = {d_c, res_q[WIDTH-1:1]};
          bow_d   = br_next_c;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bow_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bow_q   <= bow_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.diff      = diff_q;
  assign bus.bow       = bow_q;
  assign bus.bit_valid = busy_q;
  assign bus.bit_diff  = d_c;
  assign bus.bit_bow   = br_next_c;
endmodule
